// File: rtl/s298_bist_pkg.sv
// Shared types and constants for the s298 self-test controller.
package s298_bist_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned CUT_W  = 6;

  // Controller phases: one run per accepted start.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Feedback taps for x^16+x^14+x^13+x^11+1 in shift-left form: bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] POLY_TAPS = 16'hB400;

  // Pattern value whose low nibble equals this drives CUT G0 high (clears CUT state).
  localparam logic [3:0] G0_DECODE = 4'h0;

  // CUT response word, bit5..bit0.
  typedef struct packed {
    logic g133;
    logic g132;
    logic g118;
    logic g117;
    logic g67;
    logic g66;
  } cut_out_t;

  // One Fibonacci shift: shift left, parity of tapped bits into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ^(x & POLY_TAPS)};
  endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit shift register usable as a pattern LFSR (par_in = 0) or as a MISR.
module bist_lfsr16
  import s298_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] par_in,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_d;

  // Load has priority over stepping; hold otherwise.
  always_comb begin
    q_d = q;
    if (load) begin
      q_d = seed;
    end else if (en) begin
      q_d = lfsr_step(q) ^ par_in;
    end
  end

  // Register; reset returns to the seed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= seed;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/s298_bist_ctrl.sv
// Self-test driver for the s298 CUT: LFSR patterns out, MISR compaction in,
// signature compared against a golden value at the end of each run.
module s298_bist_ctrl
  import s298_bist_pkg::*;
#(
  parameter int unsigned       PAT_COUNT   = 1024,
  parameter int unsigned       INIT_CYCLES = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1,
  parameter logic [LFSR_W-1:0] GOLDEN_SIG  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              cut_g0,
  output logic              cut_g1,
  output logic              cut_g2,
  input  logic [CUT_W-1:0]  cut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [LFSR_W-1:0] signature
);

  localparam int unsigned CNT_MAX = (PAT_COUNT > INIT_CYCLES) ? PAT_COUNT : INIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(PAT_COUNT - 1);

  // Parameter sanity at elaboration.
  if (PAT_COUNT == 0) begin : g_bad_pat_count
    $error("s298_bist_ctrl: PAT_COUNT must be >= 1");
  end
  if (INIT_CYCLES == 0) begin : g_bad_init_cycles
    $error("s298_bist_ctrl: INIT_CYCLES must be >= 1");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("s298_bist_ctrl: LFSR_SEED must be nonzero");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_acc;
  logic              lfsr_en;
  logic              misr_en;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] misr_q;
  logic [LFSR_W-1:0] misr_par;
  logic [LFSR_W-1:0] misr_next;
  cut_out_t          cut_s;

  assign cut_s    = cut_out;
  assign misr_par = {10'b0, cut_s};

  // Pattern generator runs one step ahead of the CUT pins: it advances on every
  // edge that enters or stays in RUN, while the pins register its current value.
  bist_lfsr16 u_pat_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (lfsr_en),
    .load   (start_acc),
    .seed   (LFSR_SEED),
    .par_in (16'h0000),
    .q      (lfsr_q)
  );

  // Response compactor; starts from zero on every accepted start.
  bist_lfsr16 u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (misr_en),
    .load   (start_acc),
    .seed   (16'h0000),
    .par_in (misr_par),
    .q      (misr_q)
  );

  // Value the MISR takes at the coming edge, so PASS can rise together with DONE.
  always_comb begin
    misr_next = misr_q;
    if (misr_en) begin
      misr_next = lfsr_step(misr_q) ^ misr_par;
    end
  end

  // Next-state, phase counter and datapath enables.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_acc = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_INIT;
          cnt_d     = '0;
          start_acc = 1'b1;
        end
      end
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // Responses lag patterns by one cycle, so RUN index 0 carries no sample.
        misr_en = (cnt_q != '0);
        if (cnt_q == PAT_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        misr_en = 1'b1;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    lfsr_en = (state_d == ST_RUN);
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      cut_g0  <= 1'b1;
      cut_g1  <= 1'b0;
      cut_g2  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done    <= (state_d == ST_DONE);
      pass    <= (state_d == ST_DONE) && (misr_next == GOLDEN_SIG);
      if (state_d == ST_RUN) begin
        cut_g0 <= (lfsr_q[3:0] == G0_DECODE);
        cut_g1 <= lfsr_q[4];
        cut_g2 <= lfsr_q[5];
      end else begin
        cut_g0 <= 1'b1;
        cut_g1 <= 1'b0;
        cut_g2 <= 1'b0;
      end
    end
  end

  assign signature = misr_q;

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Directed bench for s298_bist_ctrl with a small registered stand-in CUT.
module tb_s298_bist_ctrl;

  localparam int unsigned P    = 8;
  localparam int unsigned I    = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] GOLD = 16'h0000;
  localparam int          LAT  = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cut_g0, cut_g1, cut_g2;
  logic [5:0]  cut_out = 6'h00;
  logic        busy, done, pass;
  logic [15:0] signature;

  logic        cut_model = 1'b0;
  logic [5:0]  cut_tie = 6'h00;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  s298_bist_ctrl #(
    .PAT_COUNT   (P),
    .INIT_CYCLES (I),
    .LFSR_SEED   (SEED),
    .GOLDEN_SIG  (GOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cut_g0    (cut_g0),
    .cut_g1    (cut_g1),
    .cut_g2    (cut_g2),
    .cut_out   (cut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  // Stand-in CUT response: an arbitrary mix of the three inputs.
  function automatic logic [5:0] cut_f(input logic g0, input logic g1, input logic g2);
    return {g2 ^ g1, g1, g0, ~g2, g2 & g0, g1 | g0};
  endfunction

  function automatic logic [15:0] shl_fb(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Expected signature for the stand-in CUT: pattern n compacted as sample n.
  function automatic logic [15:0] model_sig(input int unsigned n);
    logic [15:0] l;
    logic [15:0] m;
    l = SEED;
    m = 16'h0000;
    for (int i = 0; i < int'(n); i++) begin
      m = shl_fb(m) ^ {10'b0, cut_f(l[3:0] == 4'h0, l[4], l[5])};
      l = shl_fb(l);
    end
    return m;
  endfunction

  // Registered CUT: responds to the pins one cycle later.
  always @(posedge clk) begin
    cut_out <= cut_model ? cut_f(cut_g0, cut_g1, cut_g2) : cut_tie;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until DONE (bounded); lat counts edges from the start edge inclusive.
  task automatic wait_done(input bit mid_pulse, inout int lat);
    while (done !== 1'b1 && lat < 60) begin
      start = mid_pulse && (lat == 6);
      step();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic run(input bit mid_pulse, output int lat);
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    wait_done(mid_pulse, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
    total++; if (signature !== 16'h0000) begin bad++; $display("FAIL reset_sig got=%h want=0000", signature); end
    total++; if ({cut_g0, cut_g1, cut_g2} !== 3'b100) begin
      bad++; $display("FAIL reset_pins got=%b want=100", {cut_g0, cut_g1, cut_g2});
    end
    rst_n = 1'b1;
    step();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL idle_hold got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_timing_pattern();
    int lat;
    logic [2:0] exp_pat [3];
    exp_pat[0] = 3'b001;
    exp_pat[1] = 3'b000;
    exp_pat[2] = 3'b000;
    cut_model = 1'b0;
    cut_tie = 6'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL start_busy got busy=%b done=%b want 1 0", busy, done);
    end
    for (int c = 0; c < 4; c++) begin
      total++; if ({cut_g0, cut_g1, cut_g2} !== 3'b100) begin
        bad++; $display("FAIL init_pins c=%0d got=%b want=100", c, {cut_g0, cut_g1, cut_g2});
      end
      if (c < 3) begin
        step();
        lat++;
      end
    end
    for (int n = 0; n < 3; n++) begin
      step();
      lat++;
      total++; if ({cut_g0, cut_g1, cut_g2} !== exp_pat[n]) begin
        bad++; $display("FAIL run_pat%0d got=%b want=%b", n, {cut_g0, cut_g1, cut_g2}, exp_pat[n]);
      end
    end
    wait_done(1'b0, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL done_latency got=%0d want=%0d", lat, LAT); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy got=%b want=0", busy); end
    total++; if (signature !== 16'h0000) begin bad++; $display("FAIL zero_sig got=%h want=0000", signature); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL zero_pass got=%b want=1", pass); end
    total++; if ({cut_g0, cut_g1, cut_g2} !== 3'b100) begin
      bad++; $display("FAIL done_pins got=%b want=100", {cut_g0, cut_g1, cut_g2});
    end
  endtask

  task automatic test_start_in_done();
    int lat;
    cut_tie = 6'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    total++; if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_flags got done=%b pass=%b busy=%b want 0 0 1", done, pass, busy);
    end
    total++; if (signature !== 16'h0000) begin bad++; $display("FAIL restart_sig_clear got=%h want=0000", signature); end
    wait_done(1'b0, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL const_latency got=%0d want=%0d", lat, LAT); end
    total++; if (signature !== 16'h00FF) begin bad++; $display("FAIL const_sig got=%h want=00ff", signature); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL const_pass got=%b want=0", pass); end
  endtask

  task automatic test_model();
    int lat;
    logic [15:0] exp_sig;
    exp_sig = model_sig(P);
    cut_model = 1'b1;
    run(1'b0, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL model_latency got=%0d want=%0d", lat, LAT); end
    total++; if (signature !== exp_sig) begin bad++; $display("FAIL model_sig got=%h want=%h", signature, exp_sig); end
    total++; if (pass !== (exp_sig == GOLD)) begin
      bad++; $display("FAIL model_pass got=%b want=%b", pass, exp_sig == GOLD);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] exp_sig;
    exp_sig = model_sig(P);
    run(1'b1, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL midstart_latency got=%0d want=%0d", lat, LAT); end
    total++; if (signature !== exp_sig) begin bad++; $display("FAIL midstart_sig got=%h want=%h", signature, exp_sig); end
    run(1'b0, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL repeat_latency got=%0d want=%0d", lat, LAT); end
    total++; if (signature !== exp_sig) begin bad++; $display("FAIL repeat_sig got=%h want=%h", signature, exp_sig); end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      bad++; $display("FAIL abort_flags got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
    end
    total++; if (signature !== 16'h0000) begin bad++; $display("FAIL abort_sig got=%h want=0000", signature); end
    total++; if (cut_g0 !== 1'b1) begin bad++; $display("FAIL abort_g0 got=%b want=1", cut_g0); end
    repeat (3) step();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_recover();
    int lat;
    logic [15:0] exp_sig;
    exp_sig = model_sig(P);
    run(1'b0, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL recover_latency got=%0d want=%0d", lat, LAT); end
    total++; if (signature !== exp_sig) begin bad++; $display("FAIL recover_sig got=%h want=%h", signature, exp_sig); end
  endtask

  initial begin
    test_reset();
    test_timing_pattern();
    test_start_in_done();
    test_model();
    test_back_to_back();
    test_reset_midrun();
    test_recover();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
